// File: rtl/zoom_pkg.sv
// Shared types and constants for the ZOOM downscale scheduler.
//   X_W / Y_W : output column / line widths
//   Q_FRAC    : fractional bits of steps and weights
//   STEP_ONE  : 1.0 in Q8.8; smallest legal step
//   state_e   : scheduler FSM states
package zoom_pkg;

  localparam int unsigned X_W    = 11;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned Q_FRAC = 8;

  localparam logic [15:0] STEP_ONE = 16'h0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Steps below 1.0 would allow several emits per window; force them to 1.0.
  function automatic logic [15:0] clamp_step(input logic [15:0] step);
    return (step < STEP_ONE) ? STEP_ONE : step;
  endfunction

endpackage

// File: rtl/zoom_dda_axis.sv
// One DDA axis of the ZOOM scheduler: a saturating fixed-point accumulator that
// advances by the step and flags when its integer part lands in the current cell.
//   clk, rstn : clock, asynchronous active-low reset
//   step_i    : step added on adv_i (unsigned, FracW fractional bits)
//   idx_i     : window index; the window covers source cell idx_i - 1
//   clr_i     : clear accumulator (wins over adv_i)
//   adv_i     : advance accumulator by step_i
//   hit_o     : idx_i >= 1 and integer part == idx_i - 1
//   frac_o    : fractional part (interpolation weight)
module zoom_dda_axis #(
  parameter int unsigned IntW  = 11,
  parameter int unsigned FracW = 8,
  parameter int unsigned StepW = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [StepW-1:0] step_i,
  input  logic [IntW-1:0]  idx_i,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic             hit_o,
  output logic [FracW-1:0] frac_o
);

  localparam int unsigned AccW = IntW + FracW;
  localparam int unsigned SumW = AccW + 1;

  logic [AccW-1:0] acc_q, acc_d;
  logic [SumW-1:0] sum;
  logic [IntW-1:0] idx_m1;

  always_comb begin
    sum   = {1'b0, acc_q} + SumW'(step_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (adv_i) begin
      // Saturate rather than wrap past the top of the frame.
      acc_d = sum[AccW] ? '1 : sum[AccW-1:0];
    end
  end

  always_comb begin
    idx_m1 = idx_i - IntW'(1);
    hit_o  = (idx_i != '0) && (acc_q[AccW-1:FracW] == idx_m1);
    frac_o = acc_q[FracW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/zoom_sched.sv
// ZOOM downscale scheduler. Tracks 2x2 window strobes, walks an X/Y DDA over
// source coordinates and emits bilinear weights plus output coordinates one
// cycle after the window that contains an output pixel.
//   clk, rstn              : clock, asynchronous active-low reset
//   vga_vs                 : frame sync, high = vertical blank; fall latches config
//   cfg_step_x/_y          : Q8.8 src/dst step per axis
//   cfg_dst_w/_h           : output pixels per line / lines per frame
//   win_vld, win_hs_end    : window strobe, line-end strobe
//   out_vld/fx/fy/x/y      : emitted pixel, weights and coordinates
//   out_eol, out_eof       : last pixel of output line / frame
//   busy                   : FSM not idle
//   cfg_err                : a step below 1.0 was clamped at the last latch
module zoom_sched
  import zoom_pkg::*;
#(
  parameter int unsigned SRC_W = 1280,
  parameter int unsigned SRC_H = 720,
  parameter int unsigned FRAC  = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            vga_vs,
  input  logic [15:0]     cfg_step_x,
  input  logic [15:0]     cfg_step_y,
  input  logic [X_W-1:0]  cfg_dst_w,
  input  logic [Y_W-1:0]  cfg_dst_h,
  input  logic            win_vld,
  input  logic            win_hs_end,
  output logic            out_vld,
  output logic [FRAC-1:0] out_fx,
  output logic [FRAC-1:0] out_fy,
  output logic [X_W-1:0]  out_x,
  output logic [Y_W-1:0]  out_y,
  output logic            out_eol,
  output logic            out_eof,
  output logic            busy,
  output logic            cfg_err
);

  state_e state_q, state_d;

  logic           vs_q;
  logic           latch;
  logic [15:0]    step_x_q, step_y_q;
  logic [X_W-1:0] dst_w_q;
  logic [Y_W-1:0] dst_h_q;
  logic           cfg_err_q;

  logic [X_W-1:0] wc_q, wc_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [X_W-1:0] ox_q, ox_d;
  logic [Y_W-1:0] oy_q, oy_d;
  logic           line_emit_q, line_emit_d;

  logic            active, emit, line_end, eol, eof;
  logic            hit_x, hit_y;
  logic [FRAC-1:0] frac_x, frac_y;

  logic            out_vld_q, out_eol_q, out_eof_q;
  logic [FRAC-1:0] out_fx_q, out_fy_q;
  logic [X_W-1:0]  out_x_q;
  logic [Y_W-1:0]  out_y_q;

  // ---------------------------------------------------------------------------
  // Frame sync and config shadow
  // ---------------------------------------------------------------------------
  assign latch = vs_q & ~vga_vs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q      <= 1'b0;
      step_x_q  <= STEP_ONE;
      step_y_q  <= STEP_ONE;
      dst_w_q   <= '0;
      dst_h_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      vs_q <= vga_vs;
      if (latch) begin
        step_x_q  <= clamp_step(cfg_step_x);
        step_y_q  <= clamp_step(cfg_step_y);
        dst_w_q   <= cfg_dst_w;
        dst_h_q   <= cfg_dst_h;
        cfg_err_q <= (cfg_step_x < STEP_ONE) || (cfg_step_y < STEP_ONE);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Emit decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // vs high kills emission in the same cycle the FSM is forced to IDLE.
    active   = (state_q == ACTIVE) && !vga_vs;
    eol      = (ox_q == dst_w_q - X_W'(1));
    eof      = eol && (oy_q == dst_h_q - Y_W'(1));
    emit     = win_vld && active && hit_x && hit_y && (ox_q < dst_w_q);
    line_end = win_hs_end && active;
  end

  zoom_dda_axis #(
    .IntW  (X_W),
    .FracW (FRAC),
    .StepW (16)
  ) u_dda_x (
    .clk    (clk),
    .rstn   (rstn),
    .step_i (step_x_q),
    .idx_i  (wc_q),
    .clr_i  (latch || line_end),
    .adv_i  (emit),
    .hit_o  (hit_x),
    .frac_o (frac_x)
  );

  zoom_dda_axis #(
    .IntW  (Y_W),
    .FracW (FRAC),
    .StepW (16)
  ) u_dda_y (
    .clk    (clk),
    .rstn   (rstn),
    .step_i (step_y_q),
    .idx_i  (row_q),
    .clr_i  (latch),
    .adv_i  (line_end && (line_emit_q || emit)),
    .hit_o  (hit_y),
    .frac_o (frac_y)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (vga_vs) begin
      state_d = IDLE;
    end else if (latch) begin
      state_d = ACTIVE;
    end else if ((state_q == ACTIVE) && emit && eof) begin
      state_d = DONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Window and output counters; a same-cycle line end applies after the emit.
  // ---------------------------------------------------------------------------
  always_comb begin
    wc_d        = wc_q;
    row_d       = row_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    line_emit_d = line_emit_q;
    if (latch) begin
      wc_d        = '0;
      row_d       = '0;
      ox_d        = '0;
      oy_d        = '0;
      line_emit_d = 1'b0;
    end else if (active) begin
      if (win_vld && (wc_q != X_W'(SRC_W - 1))) begin
        wc_d = wc_q + X_W'(1);
      end
      if (emit) begin
        ox_d        = ox_q + X_W'(1);
        line_emit_d = 1'b1;
      end
      if (line_end) begin
        wc_d        = '0;
        ox_d        = '0;
        line_emit_d = 1'b0;
        if (row_q != Y_W'(SRC_H)) begin
          row_d = row_q + Y_W'(1);
        end
        if ((line_emit_q || emit) && (oy_q != '1)) begin
          oy_d = oy_q + Y_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wc_q        <= '0;
      row_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      line_emit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      row_q       <= row_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      line_emit_q <= line_emit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: strobes pulse with the emit, data holds between emits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q <= 1'b0;
      out_eol_q <= 1'b0;
      out_eof_q <= 1'b0;
      out_fx_q  <= '0;
      out_fy_q  <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      out_vld_q <= emit;
      out_eol_q <= emit && eol;
      out_eof_q <= emit && eof;
      if (emit) begin
        out_fx_q <= frac_x;
        out_fy_q <= frac_y;
        out_x_q  <= ox_q;
        out_y_q  <= oy_q;
      end
    end
  end

  assign out_vld = out_vld_q;
  assign out_eol = out_eol_q;
  assign out_eof = out_eof_q;
  assign out_fx  = out_fx_q;
  assign out_fy  = out_fy_q;
  assign out_x   = out_x_q;
  assign out_y   = out_y_q;
  assign busy    = (state_q != IDLE);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_zoom_sched.sv
// Self-checking bench for zoom_sched. Stimulus tasks push the expected pixel
// stream (from closed-form k*step positions) into a queue; a monitor pops and
// compares on every out_vld, including the cycle it is expected in.
module tb_zoom_sched;

  typedef struct packed {
    logic [7:0]  fx;
    logic [7:0]  fy;
    logic [10:0] x;
    logic [9:0]  y;
    logic        eol;
    logic        eof;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vga_vs;
  logic [15:0] cfg_step_x, cfg_step_y;
  logic [10:0] cfg_dst_w;
  logic [9:0]  cfg_dst_h;
  logic        win_vld, win_hs_end;
  logic        out_vld;
  logic [7:0]  out_fx, out_fy;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        out_eol, out_eof, busy, cfg_err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Bench-side frame model (effective, i.e. already clamped, config).
  int cur_sx, cur_sy, cur_dw, cur_dh, cur_row;
  bit frame_active, frame_done;

  zoom_sched #(
    .SRC_W (1280),
    .SRC_H (720),
    .FRAC  (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .vga_vs     (vga_vs),
    .cfg_step_x (cfg_step_x),
    .cfg_step_y (cfg_step_y),
    .cfg_dst_w  (cfg_dst_w),
    .cfg_dst_h  (cfg_dst_h),
    .win_vld    (win_vld),
    .win_hs_end (win_hs_end),
    .out_vld    (out_vld),
    .out_fx     (out_fx),
    .out_fy     (out_fy),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: every out_vld must match the next queued expectation.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_emit: got x=%0d y=%0d cyc=%0d, required no emit",
                 out_x, out_y, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_fx, out_fy, out_x, out_y, out_eol, out_eof} !==
            {mon_e.fx, mon_e.fy, mon_e.x, mon_e.y, mon_e.eol, mon_e.eof} ||
            cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL emit: got fx=%h fy=%h x=%0d y=%0d eol=%b eof=%b cyc=%0d, required fx=%h fy=%h x=%0d y=%0d eol=%b eof=%b cyc=%0d",
                   out_fx, out_fy, out_x, out_y, out_eol, out_eof, cyc,
                   mon_e.fx, mon_e.fy, mon_e.x, mon_e.y, mon_e.eol, mon_e.eof, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Blank for a few cycles, then drop vs so the config is latched.
  task automatic vs_pulse(input logic [15:0] sx, input logic [15:0] sy, input int dw,
                          input int dh, input int eff_sx, input int eff_sy,
                          input bit req_err);
    @(negedge clk);
    vga_vs     = 1'b1;
    win_vld    = 1'b0;
    win_hs_end = 1'b0;
    cfg_step_x = sx;
    cfg_step_y = sy;
    cfg_dst_w  = 11'(dw);
    cfg_dst_h  = 10'(dh);
    repeat (3) @(negedge clk);
    vga_vs = 1'b0;
    @(negedge clk);
    check("busy_after_latch", 64'(busy), 64'd1);
    check("cfg_err_after_latch", 64'(cfg_err), 64'(req_err));
    cur_sx       = eff_sx;
    cur_sy       = eff_sy;
    cur_dw       = dw;
    cur_dh       = dh;
    cur_row      = 0;
    frame_active = 1'b1;
    frame_done   = 1'b0;
  endtask

  // Drive ncols consecutive window strobes of the current row, pushing the
  // pixels that should fall in them. Output k sits at source x = k*step_x,
  // i.e. in window floor(k*step_x)+1, and appears one cycle later.
  task automatic drive_wins(input int ncols, input bit last_with_hs);
    int   c0, j_hit, pos, col;
    exp_t e;
    @(negedge clk);
    c0    = cyc;
    j_hit = -1;
    if (frame_active && !frame_done && cur_row >= 1) begin
      for (int j = 0; j < cur_dh; j++) begin
        if (((j * cur_sy) >> 8) + 1 == cur_row) j_hit = j;
      end
    end
    if (j_hit >= 0) begin
      for (int k = 0; k < cur_dw; k++) begin
        pos = k * cur_sx;
        col = (pos >> 8) + 1;
        if (col < ncols) begin
          e.fx  = pos[7:0];
          e.fy  = 8'(j_hit * cur_sy);
          e.x   = 11'(k);
          e.y   = 10'(j_hit);
          e.eol = (k == cur_dw - 1);
          e.eof = e.eol && (j_hit == cur_dh - 1);
          e.cyc = c0 + col + 1;
          exp_q.push_back(e);
          if (e.eof) frame_done = 1'b1;
        end
      end
    end
    for (int i = 0; i < ncols; i++) begin
      if (i > 0) @(negedge clk);
      win_vld    = 1'b1;
      win_hs_end = last_with_hs && (i == ncols - 1);
    end
  endtask

  task automatic drive_line(input int ncols, input bit same);
    drive_wins(ncols, same);
    @(negedge clk);
    win_vld    = 1'b0;
    win_hs_end = 1'b0;
    if (!same) begin
      @(negedge clk);
      win_hs_end = 1'b1;
      @(negedge clk);
      win_hs_end = 1'b0;
    end
    cur_row++;
  endtask

  initial begin
    rstn         = 1'b0;
    vga_vs       = 1'b0;
    cfg_step_x   = 16'h0100;
    cfg_step_y   = 16'h0100;
    cfg_dst_w    = '0;
    cfg_dst_h    = '0;
    win_vld      = 1'b0;
    win_hs_end   = 1'b0;
    frame_active = 1'b0;
    frame_done   = 1'b0;
    cur_row      = 0;
    #3;
    check("reset_outputs",
          64'({out_vld, out_fx, out_fy, out_x, out_y, out_eol, out_eof, busy, cfg_err}),
          64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // 1:1 steps, every window except wc=0/row=0 emits; eof at wc=1279 of last row.
    vs_pulse(16'h0100, 16'h0100, 1279, 3, 256, 256, 1'b0);
    repeat (4) drive_line(1280, 1'b0);
    check("busy_in_done", 64'(busy), 64'd1);
    drive_line(1280, 1'b0);  // DONE: strobes ignored

    // 2:1 both ways: odd windows of odd rows.
    vs_pulse(16'h0200, 16'h0200, 640, 2, 512, 512, 1'b0);
    repeat (4) drive_line(1280, 1'b0);

    // 1.5 horizontal: fx alternates 00/80; cfg inputs changed after latch are ignored.
    vs_pulse(16'h0180, 16'h0100, 10, 2, 384, 256, 1'b0);
    cfg_step_x = 16'h0300;
    cfg_dst_w  = 11'd5;
    repeat (4) drive_line(20, 1'b0);

    // Step below 1.0 clamps to 1.0; dst_w beyond source width never reaches eol;
    // last line ends with win_vld and win_hs_end together.
    vs_pulse(16'h0080, 16'h0100, 2000, 3, 256, 256, 1'b1);
    repeat (2) drive_line(1280, 1'b0);
    drive_line(5, 1'b1);

    // vs asserted mid-line: emission stops at once, next frame restarts at 0,0.
    vs_pulse(16'h0100, 16'h0100, 50, 5, 256, 256, 1'b0);
    drive_line(20, 1'b0);
    drive_wins(10, 1'b0);
    @(negedge clk);
    vga_vs  = 1'b1;  // window wc=10 would emit if still active
    win_vld = 1'b1;
    @(negedge clk);
    win_vld = 1'b0;
    check("vs_mid_out_vld", 64'(out_vld), 64'd0);
    check("vs_mid_busy", 64'(busy), 64'd0);
    frame_active = 1'b0;
    vs_pulse(16'h0100, 16'h0100, 50, 5, 256, 256, 1'b0);
    drive_line(8, 1'b0);
    drive_line(6, 1'b0);

    // Asynchronous reset mid-frame, with cfg_err set beforehand.
    vs_pulse(16'h0080, 16'h0100, 20, 5, 256, 256, 1'b1);
    drive_line(8, 1'b0);
    drive_line(6, 1'b0);
    check("pre_reset_out_x", 64'(out_x), 64'd4);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs",
          64'({out_vld, out_fx, out_fy, out_x, out_y, out_eol, out_eof, busy, cfg_err}),
          64'd0);
    @(negedge clk);
    rstn         = 1'b1;
    frame_active = 1'b0;
    cur_row      = 0;
    drive_line(8, 1'b0);  // no vs fall yet: nothing may emit
    drive_line(8, 1'b0);
    check("post_reset_busy", 64'(busy), 64'd0);
    vs_pulse(16'h0100, 16'h0100, 20, 5, 256, 256, 1'b0);
    drive_line(8, 1'b0);
    drive_line(6, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
